// File: rtl/flags_pkg.sv
// flags_pkg: shared types for the condition-flag unit.
package flags_pkg;
    localparam int FLAGS_W = 4;

    typedef enum logic [2:0] {
        F_NONE,
        F_ADD,
        F_ADC,
        F_SUB,
        F_SBC,
        F_CMP,
        F_LOGIC,
        F_SHIFT
    } flag_op_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;
endpackage

// File: rtl/flags_if.sv
// flags_if: control-unit to flag-unit bundle; master drives strobes, slave returns registered state.
interface flags_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
);
    import flags_pkg::*;
    logic                       ACLOAD;
    flag_op_t                   op_class;
    logic [WIDTH-1:0]           op1;
    logic [WIDTH-1:0]           op2;
    logic [WIDTH-1:0]           AC_result;
    logic                       flags_wr;
    logic [FLAGS_W-1:0]         flags_wdata;
    logic                       push;
    logic                       pop;
    logic                       err_clr;
    logic                       N;
    logic                       Z;
    logic                       C;
    logic                       V;
    logic [$clog2(DEPTH+1)-1:0] depth;
    logic                       ovf_err;
    logic                       unf_err;

    modport master (
        output ACLOAD, op_class, op1, op2, AC_result, flags_wr, flags_wdata, push, pop, err_clr,
        input  N, Z, C, V, depth, ovf_err, unf_err
    );

    modport slave (
        input  ACLOAD, op_class, op1, op2, AC_result, flags_wr, flags_wdata, push, pop, err_clr,
        output N, Z, C, V, depth, ovf_err, unf_err
    );
endinterface

// File: rtl/flags_stack.sv
// flags_stack: LIFO of saved flag words; simultaneous push and pop leave it untouched.
module flags_stack
    import flags_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  flags_t                     i_wdata,
    output flags_t                     o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_depth,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int DPW = $clog2(DEPTH + 1);

    // sized to the full pointer range so the pointer indexes it without truncation
    flags_t           r_mem [2**DPW];
    logic [DPW-1:0]   r_depth;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_depth == DPW'(DEPTH));
    assign o_empty   = (r_depth == '0);
    assign o_depth   = r_depth;
    assign o_rdata   = r_mem[r_depth - 1'b1];
    assign w_do_push = i_push && !i_pop && !o_full;
    assign w_do_pop  = i_pop && !i_push && !o_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_depth <= '0;
        else if (w_do_push)
            r_depth <= r_depth + 1'b1;
        else if (w_do_pop)
            r_depth <= r_depth - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_do_push)
            r_mem[r_depth] <= i_wdata;
    end
endmodule

// File: rtl/flags_unit.sv
// flags_unit: N/Z/C/V generation for a WIDTH-bit ALU, flag register with carry chaining,
// and a hardware flag stack for interrupt entry and RETI.
module flags_unit
    import flags_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    flags_if.slave bus
);
    flags_t           r_flags;
    flags_t           w_upd;
    flags_t           w_top;
    flags_t           w_next;
    logic             r_ovf;
    logic             r_unf;
    logic             w_full;
    logic             w_empty;
    logic             w_is_add;
    logic             w_is_sub;
    logic             w_arith;
    logic             w_cin;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic             w_pop_ok;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_is_add = (bus.op_class == F_ADD) || (bus.op_class == F_ADC);
    assign w_is_sub = (bus.op_class == F_SUB) || (bus.op_class == F_SBC) || (bus.op_class == F_CMP);
    assign w_arith  = w_is_add || w_is_sub;
    // subtraction is op1 + ~op2 + cin, so C reads as "no borrow"
    assign w_cin    = (bus.op_class == F_ADC || bus.op_class == F_SBC) ? r_flags.c : w_is_sub;
    assign w_b      = w_is_sub ? ~bus.op2 : bus.op2;
    assign w_sum    = {1'b0, bus.op1} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};

    // with op2 already inverted for subtracts, one overflow rule covers both directions
    always_comb begin
        w_upd.n = bus.AC_result[WIDTH-1];
        w_upd.z = (bus.AC_result == '0);
        w_upd.c = w_arith ? w_sum[WIDTH] : (bus.op_class == F_SHIFT) ? bus.op1[WIDTH-1] : r_flags.c;
        w_upd.v = w_arith ? ((bus.op1[WIDTH-1] == w_b[WIDTH-1]) && (bus.AC_result[WIDTH-1] != bus.op1[WIDTH-1]))
                          : r_flags.v;
    end

    assign w_pop_ok  = bus.pop && !w_empty;
    assign w_ovf_set = bus.push && !bus.pop && w_full;
    assign w_unf_set = bus.pop && w_empty;
    assign w_next    = w_pop_ok ? w_top
                     : bus.flags_wr ? flags_t'(bus.flags_wdata)
                     : (bus.ACLOAD && bus.op_class != F_NONE) ? w_upd
                     : r_flags;

    flags_stack #(.DEPTH(DEPTH)) u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.push),
        .i_pop   (bus.pop),
        .i_wdata (r_flags),
        .o_rdata (w_top),
        .o_depth (bus.depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_flags <= w_next;
            r_ovf   <= (r_ovf && !bus.err_clr) || w_ovf_set;
            r_unf   <= (r_unf && !bus.err_clr) || w_unf_set;
        end
    end

    assign bus.N       = r_flags.n;
    assign bus.Z       = r_flags.z;
    assign bus.C       = r_flags.c;
    assign bus.V       = r_flags.v;
    assign bus.ovf_err = r_ovf;
    assign bus.unf_err = r_unf;
endmodule

// File: tb/tb_flags_unit.sv
// tb_flags_unit: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_flags_unit;
    import flags_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    flags_if #(.WIDTH(12), .DEPTH(4)) bus();
    flags_unit #(.WIDTH(12), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    logic [3:0] m_f;
    logic       m_ovf;
    logic       m_unf;
    logic [3:0] m_stk[$];

    function automatic logic [3:0] flg();
        return {bus.N, bus.Z, bus.C, bus.V};
    endfunction

    function automatic int sx(input logic [11:0] v);
        return v[11] ? int'(v) - 4096 : int'(v);
    endfunction

    task automatic idle();
        bus.ACLOAD = 0; bus.op_class = F_NONE; bus.op1 = '0; bus.op2 = '0; bus.AC_result = '0;
        bus.flags_wr = 0; bus.flags_wdata = '0; bus.push = 0; bus.pop = 0; bus.err_clr = 0;
    endtask

    task automatic model_reset();
        m_f = '0; m_ovf = 0; m_unf = 0; m_stk.delete();
    endtask

    // drives one cycle and advances the reference model by the documented rules
    task automatic step(input logic ld, input flag_op_t op, input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] res, input logic wr, input logic [3:0] wd,
                        input logic ps, input logic pp, input logic ec);
        logic [3:0] upd, nf;
        int r, cin, bor;
        logic ov_set, un_set;
        bus.ACLOAD = ld; bus.op_class = op; bus.op1 = a; bus.op2 = b; bus.AC_result = res;
        bus.flags_wr = wr; bus.flags_wdata = wd; bus.push = ps; bus.pop = pp; bus.err_clr = ec;
        upd = {res[11], res == 12'd0, m_f[1], m_f[0]};
        if (op == F_ADD || op == F_ADC) begin
            cin = (op == F_ADC) ? int'(m_f[1]) : 0;
            upd[1] = (int'(a) + int'(b) + cin) > 4095;
            r = sx(a) + sx(b) + cin;
            upd[0] = (r > 2047) || (r < -2048);
        end else if (op == F_SUB || op == F_SBC || op == F_CMP) begin
            bor = (op == F_SBC) ? int'(!m_f[1]) : 0;
            upd[1] = (int'(a) - int'(b) - bor) >= 0;
            r = sx(a) - sx(b) - bor;
            upd[0] = (r > 2047) || (r < -2048);
        end else if (op == F_SHIFT) begin
            upd[1] = a[11];
        end
        nf = m_f;
        if (pp && m_stk.size() > 0) nf = m_stk[$];
        else if (wr) nf = wd;
        else if (ld && op != F_NONE) nf = upd;
        ov_set = ps && !pp && m_stk.size() == 4;
        un_set = pp && m_stk.size() == 0;
        if (ps && !pp && !ov_set) m_stk.push_back(m_f);
        else if (pp && !ps && m_stk.size() > 0) void'(m_stk.pop_back());
        m_ovf = (m_ovf && !ec) || ov_set;
        m_unf = (m_unf && !ec) || un_set;
        m_f = nf;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        model_reset();
        #12;
        checks++; if (flg() !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", flg()); end
        checks++; if (bus.depth !== 3'd0) begin errors++; $display("FAIL reset_depth: got %0d want 0", bus.depth); end
        checks++; if ({bus.ovf_err, bus.unf_err} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", {bus.ovf_err, bus.unf_err}); end
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        step(1, F_CMP, 12'h005, 12'h002, 12'h003, 0, 0, 0, 0, 0);
        checks++; if (flg() !== 4'b0010) begin errors++; $display("FAIL cmp_after_reset: got %b want 0010", flg()); end
    endtask

    task automatic test_add();
        step(1, F_ADD, 12'hFFF, 12'h001, 12'h000, 0, 0, 0, 0, 0);
        checks++; if (flg() !== 4'b0110) begin errors++; $display("FAIL add_wrap: got %b want 0110", flg()); end
        step(1, F_ADD, 12'h7FF, 12'h001, 12'h800, 0, 0, 0, 0, 0);
        checks++; if (flg() !== 4'b1001) begin errors++; $display("FAIL add_ovf: got %b want 1001", flg()); end
        step(1, F_SUB, 12'h800, 12'h001, 12'h7FF, 0, 0, 0, 0, 0);
        checks++; if (flg() !== 4'b0011) begin errors++; $display("FAIL sub_ovf: got %b want 0011", flg()); end
        step(0, F_ADD, 12'hFFF, 12'h001, 12'h000, 0, 0, 0, 0, 0);
        checks++; if (flg() !== 4'b0011) begin errors++; $display("FAIL no_acload: got %b want 0011", flg()); end
    endtask

    task automatic test_carry_chain();
        logic [35:0] x, y;
        logic [63:0] lo;
        step(1, F_ADD, 12'hFFF, 12'h001, 12'h000, 0, 0, 0, 0, 0);
        checks++; if (bus.C !== 1'b1) begin errors++; $display("FAIL chain_add_c: got %b want 1", bus.C); end
        step(1, F_ADC, 12'h000, 12'h000, 12'h001, 0, 0, 0, 0, 0);
        checks++; if (flg() !== 4'b0000) begin errors++; $display("FAIL chain_adc: got %b want 0000", flg()); end
        step(0, F_NONE, 0, 0, 0, 1, 4'b0011, 0, 0, 0);
        step(1, F_LOGIC, 12'h0F0, 12'h0FF, 12'h800, 0, 0, 0, 0, 0);
        checks++; if (flg() !== 4'b1011) begin errors++; $display("FAIL logic_hold: got %b want 1011", flg()); end
        step(1, F_SHIFT, 12'h400, 12'h000, 12'h000, 0, 0, 0, 0, 0);
        checks++; if (flg() !== 4'b0101) begin errors++; $display("FAIL shift_c: got %b want 0101", flg()); end
        // 36-bit add and subtract chained over three words, checked against wide arithmetic
        for (int t = 0; t < 6; t++) begin
            x = {$urandom, $urandom}; y = {$urandom, $urandom};
            for (int k = 0; k < 3; k++) begin
                lo = 64'(x[12*k +: 12]) + 64'(y[12*k +: 12]) + ((k == 0) ? 64'd0 : 64'(m_f[1]));
                step(1, (k == 0) ? F_ADD : F_ADC, x[12*k +: 12], y[12*k +: 12], lo[11:0], 0, 0, 0, 0, 0);
            end
            lo = 64'(x) + 64'(y);
            checks++; if (bus.C !== lo[36]) begin errors++; $display("FAIL adc36_c: got %b want %b", bus.C, lo[36]); end
            for (int k = 0; k < 3; k++) begin
                lo = 64'(x[12*k +: 12]) - 64'(y[12*k +: 12]) - ((k == 0) ? 64'd0 : 64'(!m_f[1]));
                step(1, (k == 0) ? F_SUB : F_SBC, x[12*k +: 12], y[12*k +: 12], lo[11:0], 0, 0, 0, 0, 0);
            end
            checks++; if (bus.C !== (x >= y)) begin errors++; $display("FAIL sbc36_c: got %b want %b", bus.C, x >= y); end
        end
    endtask

    task automatic test_stack();
        logic [3:0] vals[4];
        vals[0] = 4'b0001; vals[1] = 4'b0010; vals[2] = 4'b0100; vals[3] = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            step(0, F_NONE, 0, 0, 0, 1, vals[i], 0, 0, 0);
            step(0, F_NONE, 0, 0, 0, 0, 0, 1, 0, 0);
        end
        checks++; if (bus.depth !== 3'd4) begin errors++; $display("FAIL push4_depth: got %0d want 4", bus.depth); end
        step(0, F_NONE, 0, 0, 0, 0, 0, 1, 0, 0);
        checks++; if ({bus.ovf_err, bus.depth} !== {1'b1, 3'd4}) begin errors++; $display("FAIL push5_ovf: got ovf=%b depth=%0d want ovf=1 depth=4", bus.ovf_err, bus.depth); end
        for (int i = 3; i >= 0; i--) begin
            step(0, F_NONE, 0, 0, 0, 0, 0, 0, 1, 0);
            checks++; if (flg() !== vals[i]) begin errors++; $display("FAIL pop_%0d: got %b want %b", i, flg(), vals[i]); end
        end
        step(0, F_NONE, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if ({bus.unf_err, flg(), bus.depth} !== {1'b1, 4'b0001, 3'd0}) begin errors++; $display("FAIL pop5_unf: got unf=%b flags=%b depth=%0d want unf=1 flags=0001 depth=0", bus.unf_err, flg(), bus.depth); end
        step(0, F_NONE, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++; if ({bus.ovf_err, bus.unf_err} !== 2'b00) begin errors++; $display("FAIL err_clr: got %b want 00", {bus.ovf_err, bus.unf_err}); end
        step(0, F_NONE, 0, 0, 0, 0, 0, 0, 1, 1);
        checks++; if (bus.unf_err !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", bus.unf_err); end
        step(1, F_ADD, 12'h001, 12'h001, 12'h002, 0, 0, 0, 1, 1);
        checks++; if ({bus.unf_err, flg()} !== {1'b1, 4'b0000}) begin errors++; $display("FAIL unf_with_update: got %b want 10000", {bus.unf_err, flg()}); end
        step(0, F_NONE, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_priority();
        step(0, F_NONE, 0, 0, 0, 1, 4'b1010, 0, 0, 0);
        step(0, F_NONE, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, F_NONE, 0, 0, 0, 1, 4'b0011, 0, 0, 0);
        step(1, F_ADD, 12'h001, 12'h001, 12'h002, 1, 4'b0101, 0, 1, 0);
        checks++; if ({flg(), bus.depth} !== {4'b1010, 3'd0}) begin errors++; $display("FAIL prio_pop: got flags=%b depth=%0d want 1010 0", flg(), bus.depth); end
        step(1, F_ADD, 12'hFFF, 12'h001, 12'h000, 0, 0, 1, 0, 0);
        checks++; if ({flg(), bus.depth} !== {4'b0110, 3'd1}) begin errors++; $display("FAIL push_acload: got flags=%b depth=%0d want 0110 1", flg(), bus.depth); end
        step(0, F_NONE, 0, 0, 0, 1, 4'b1111, 1, 1, 0);
        checks++; if ({flg(), bus.depth} !== {4'b1010, 3'd1}) begin errors++; $display("FAIL push_pop: got flags=%b depth=%0d want 1010 1", flg(), bus.depth); end
        step(0, F_NONE, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (flg() !== 4'b1010) begin errors++; $display("FAIL pre_update_saved: got %b want 1010", flg()); end
    endtask

    task automatic test_random();
        flag_op_t op;
        logic [11:0] a, b, res;
        for (int i = 0; i < 500; i++) begin
            op = flag_op_t'($urandom_range(0, 7));
            a = 12'($urandom); b = 12'($urandom);
            if (op == F_ADD || op == F_ADC)
                res = 12'(int'(a) + int'(b) + ((op == F_ADC) ? int'(m_f[1]) : 0));
            else if (op == F_SUB || op == F_CMP || op == F_SBC)
                res = 12'(int'(a) - int'(b) - ((op == F_SBC) ? int'(!m_f[1]) : 0));
            else
                res = ($urandom_range(0, 3) == 0) ? 12'd0 : 12'($urandom);
            step($urandom_range(0, 3) != 0, op, a, b, res, $urandom_range(0, 7) == 0, 4'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
            checks++;
            if ({flg(), bus.depth, bus.ovf_err, bus.unf_err} !== {m_f, 3'(m_stk.size()), m_ovf, m_unf}) begin
                errors++;
                $display("FAIL random_%0d: got flags=%b depth=%0d ovf=%b unf=%b want flags=%b depth=%0d ovf=%b unf=%b",
                         i, flg(), bus.depth, bus.ovf_err, bus.unf_err, m_f, m_stk.size(), m_ovf, m_unf);
            end
        end
    endtask

    task automatic test_async_reset();
        step(0, F_NONE, 0, 0, 0, 1, 4'b1111, 0, 0, 0);
        step(0, F_NONE, 0, 0, 0, 0, 0, 1, 0, 0);
        bus.push = 1;
        @(posedge clk); #3;
        rst = 0;
        #1;
        checks++;
        if ({flg(), bus.depth, bus.ovf_err, bus.unf_err} !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: got flags=%b depth=%0d ovf=%b unf=%b want all 0", flg(), bus.depth, bus.ovf_err, bus.unf_err);
        end
        @(posedge clk); #1;
        idle();
        model_reset();
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if ({flg(), bus.depth} !== 7'd0) begin errors++; $display("FAIL after_release: got flags=%b depth=%0d want 0", flg(), bus.depth); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_chain();
        test_stack();
        test_priority();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/flags_unit.md
# flags_unit

Parametrised condition-flag unit for the CPU datapath: a successor to the fixed 12-bit flag setter. It computes N/Z/C/V for a WIDTH-bit ALU result, holds them in a flag register, and supports carry-chained ADC/SBC. It also provides a DEPTH-entry hardware flag stack for interrupt entry and RETI. It sits beside the accumulator; the control unit drives it from the decoded opcode and the AC load strobe.

## Interface
- WIDTH, 12, datapath width in bits (≥4)
- DEPTH, 4, flag-stack entries (≥1; power of two not required)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ACLOAD  in  1  flag-update strobe, aligned with the AC write
- op_class  in  3  flag_op_t operation class, from the package
- op1  in  WIDTH  ALU operand A
- op2  in  WIDTH  ALU operand B
- AC_result  in  WIDTH  ALU result being written to AC (for CMP, the discarded difference)
- flags_wr  in  1  direct flag write (SETF)
- flags_wdata  in  4  {N,Z,C,V} for a direct write
- push  in  1  save current flags to the stack
- pop  in  1  restore flags from the stack
- err_clr  in  1  clear sticky error bits
- N, Z, C, V  out  1 each  registered flags
- depth  out  $clog2(DEPTH+1)  occupied stack entries
- ovf_err  out  1  sticky: push attempted while full
- unf_err  out  1  sticky: pop attempted while empty

## Operation
- Flag classes (flag_op_t):
  - F_NONE: no flag change.
  - F_ADD: op1+op2.
  - F_ADC: op1+op2+C.
  - F_SUB: op1−op2.
  - F_SBC: op1−op2−(~C).
  - F_CMP: same as SUB; AC not written, but flags update.
  - F_LOGIC: N/Z only; C and V held.
  - F_SHIFT: N/Z; C = op1[WIDTH-1]; V held.
- N = AC_result[WIDTH-1].
- Z = (AC_result == 0).
- Add carry: C = bit WIDTH of the (WIDTH+1)-bit sum.
- Add overflow: V = (op1[W-1]==op2[W-1]) && (AC_result[W-1]!=op1[W-1]).
- Subtract carry is the no-borrow convention: C = 1 when op1 ≥ op2 (+borrow-in), unsigned. The difference is computed as op1 + ~op2 + cin, with cin = 1 for SUB/CMP and cin = C for SBC.
- Subtract overflow: V = (op1[W-1]!=op2[W-1]) && (AC_result[W-1]!=op1[W-1]).
- An update occurs only when ACLOAD=1 and op_class≠F_NONE.
- Push writes the current registered {N,Z,C,V}, i.e. pre-update flags, to stack[depth], then depth+1.
- Pop loads {N,Z,C,V} from stack[depth-1], then depth−1.
- Same-cycle priority for the flag register: pop > flags_wr > ACLOAD update.
- push and pop in the same cycle: stack unchanged; flags get pop data only if depth>0, else the error path applies to pop alone.
- Push while depth==DEPTH: stack and depth unchanged; ovf_err←1.
- Pop while depth==0: flags and depth unchanged; unf_err←1. A concurrent flags_wr or ACLOAD update still applies.
- err_clr clears both errors. If a new error occurs in the same cycle, set wins.

## Timing
- All outputs are registered. Flags, depth and errors change at the clk edge where the strobe is sampled and are visible one cycle later. There is no combinational path from inputs to outputs.
- ADC/SBC use the C value registered before the edge, so back-to-back chained ops work every cycle.
- Reset (rst=0, asynchronous, at any time including mid-push or mid-pop):
  - N=Z=C=V=0.
  - depth=0.
  - ovf_err=unf_err=0.
  - Stack contents are don't-care.
- Release from reset is synchronous to clk.

## Structure
- Package flags_pkg:
  - flag_op_t enum.
  - flags_t packed struct {N,Z,C,V}.
  - FLAGS_W=4.
- Sub-module flags_stack holds the LIFO storage and pointer, with push/pop/full/empty. flags_unit contains the arithmetic flag logic and the priority mux.

## Test plan
- Reset:
  - rst=0 → all flags, depth and errors 0.
  - Then W=12, ACLOAD=1, F_CMP, op1=0x005, op2=0x002, AC_result=0x003 → NZCV=0010.
- F_ADD:
  - 0xFFF+0x001=0x000 → 0110.
  - Then 0x7FF+0x001=0x800 → 1001.
  - Then F_SUB 0x800−0x001=0x7FF → 0011.
- Carry chain:
  - F_ADD 0xFFF+0x001 sets C=1.
  - Next cycle F_ADC 0x000+0x000, AC_result=0x001 → NZCV=0000.
  - F_LOGIC afterwards leaves C/V unchanged.
- Stack, DEPTH=4:
  - Push 4 distinct flag values → depth=4.
  - 5th push → ovf_err=1, depth=4.
  - 4 pops restore the values in reverse order.
  - 5th pop → unf_err=1, flags unchanged.
  - err_clr → both errors 0.
- Priority:
  - Same cycle pop (top=1010), flags_wr=0101, ACLOAD ADD → flags=1010.
  - Push+ACLOAD → stack holds the pre-update flags.
- Assert rst=0 between clock edges while push is high → outputs clear immediately; depth stays 0 after release.
